// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - handshake and decoded-field bundle for the decode stage
interface decode_stage_if #(
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    // Upstream (fetch) side
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instruction;
    logic [PC_WIDTH-1:0]  pc;
    logic                 flush;

    // Downstream (register-file / execute) side
    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           opcode;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shift;
    logic [5:0]           funct;
    logic [IMM_WIDTH-1:0] imm_ext;
    logic [25:0]          jump_target;
    logic [PC_WIDTH-1:0]  pc_out;
    logic                 is_rtype;
    logic                 is_jtype;

    // Status
    logic                 hazard;
    logic [CNT_WIDTH-1:0] stall_count;

    // Environment view: drives instructions in and consumes decoded entries
    modport master (
        output in_valid, instruction, pc, flush, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, shift, funct,
               imm_ext, jump_target, pc_out, is_rtype, is_jtype,
               hazard, stall_count
    );

    // Stage view
    modport slave (
        input  in_valid, instruction, pc, flush, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, shift, funct,
               imm_ext, jump_target, pc_out, is_rtype, is_jtype,
               hazard, stall_count
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered MIPS-style decode stage with load-use stall and flush
module decode_stage #(
    parameter int         PC_WIDTH    = 32,
    parameter int         IMM_WIDTH   = 32,
    parameter logic [5:0] LOAD_OPCODE = 6'h23,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic          clock,
    input  logic          reset,
    decode_stage_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stateType;

    stateType             state;
    stateType             nextState;

    // Held entry
    logic [5:0]           opcodeReg;
    logic [4:0]           rsReg;
    logic [4:0]           rtReg;
    logic [4:0]           rdReg;
    logic [4:0]           shiftReg;
    logic [5:0]           functReg;
    logic [IMM_WIDTH-1:0] immExtReg;
    logic [25:0]          jumpTargetReg;
    logic [PC_WIDTH-1:0]  pcReg;
    logic                 isRtypeReg;
    logic                 isJtypeReg;
    logic [CNT_WIDTH-1:0] stallCount;

    // Incoming instruction fields
    logic [5:0]           inOpcode;
    logic [4:0]           inRs;
    logic [4:0]           inRt;
    logic [15:0]          inImm;
    logic [IMM_WIDTH-1:0] inImmExt;

    // Handshake
    logic                 hazardNow;
    logic                 inReady;
    logic                 accept;
    logic                 isFull;

    // Logical immediates are zero-extended, lui places the half-word on top
    // when there is room for it, everything else is sign-extended. A 64-bit
    // scratch value keeps the selection independent of IMM_WIDTH.
    function automatic logic [IMM_WIDTH-1:0] extendImm(input logic [5:0] op,
                                                       input logic [15:0] imm);
        logic [63:0] wide;
        case (op)
            6'h0C, 6'h0D, 6'h0E: wide = {48'd0, imm};
            6'h0F: begin
                if (IMM_WIDTH >= 32) begin
                    wide = {32'd0, imm, 16'd0};
                end else begin
                    wide = {48'd0, imm};
                end
            end
            default: begin
                if (IMM_WIDTH == 16) begin
                    wide = {48'd0, imm};
                end else begin
                    wide = {{48{imm[15]}}, imm};
                end
            end
        endcase
        return wide[IMM_WIDTH-1:0];
    endfunction

    assign isFull   = (state == FULL);
    assign inOpcode = bus.instruction[31:26];
    assign inRs     = bus.instruction[25:21];
    assign inRt     = bus.instruction[20:16];
    assign inImm    = bus.instruction[15:0];
    assign inImmExt = extendImm(inOpcode, inImm);

    // Load-use detection and input handshake; flush always opens the input so
    // upstream can drop whatever it is presenting.
    always_comb begin
        hazardNow = 1'b0;
        inReady   = 1'b0;
        accept    = 1'b0;
        if (isFull && (opcodeReg == LOAD_OPCODE) && (rtReg != 5'd0) && bus.in_valid
            && ((inRs == rtReg) || (inRt == rtReg))) begin
            hazardNow = 1'b1;
        end
        inReady = bus.flush | (~hazardNow & (~isFull | bus.out_ready));
        accept  = bus.in_valid & inReady & ~bus.flush;
    end

    // Occupancy state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Occupancy next state: flush empties, accept fills (also on replace),
    // departure without replacement empties.
    always_comb begin
        nextState = state;
        if (bus.flush) begin
            nextState = EMPTY;
        end else if (accept) begin
            nextState = FULL;
        end else if (isFull && bus.out_ready) begin
            nextState = EMPTY;
        end
    end

    // Decoded field register; fields keep their last values once the entry leaves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcodeReg     <= '0;
            rsReg         <= '0;
            rtReg         <= '0;
            rdReg         <= '0;
            shiftReg      <= '0;
            functReg      <= '0;
            immExtReg     <= '0;
            jumpTargetReg <= '0;
            pcReg         <= '0;
            isRtypeReg    <= 1'b0;
            isJtypeReg    <= 1'b0;
        end else if (accept) begin
            opcodeReg     <= inOpcode;
            rsReg         <= inRs;
            rtReg         <= inRt;
            rdReg         <= bus.instruction[15:11];
            shiftReg      <= bus.instruction[10:6];
            functReg      <= bus.instruction[5:0];
            immExtReg     <= inImmExt;
            jumpTargetReg <= bus.instruction[25:0];
            pcReg         <= bus.pc;
            isRtypeReg    <= (inOpcode == 6'h00);
            isJtypeReg    <= (inOpcode == 6'h02) || (inOpcode == 6'h03);
        end
    end

    // Saturating count of hazard cycles, counted even when a flush overrides the stall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
        end else if (hazardNow && (stallCount != {CNT_WIDTH{1'b1}})) begin
            stallCount <= stallCount + CNT_WIDTH'(1);
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.hazard      = hazardNow;
    assign bus.out_valid   = isFull;
    assign bus.opcode      = opcodeReg;
    assign bus.rs          = rsReg;
    assign bus.rt          = rtReg;
    assign bus.rd          = rdReg;
    assign bus.shift       = shiftReg;
    assign bus.funct       = functReg;
    assign bus.imm_ext     = immExtReg;
    assign bus.jump_target = jumpTargetReg;
    assign bus.pc_out      = pcReg;
    assign bus.is_rtype    = isRtypeReg;
    assign bus.is_jtype    = isJtypeReg;
    assign bus.stall_count = stallCount;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the 32-bit MIPS-style datapath. It sits between fetch and the register-file/execute stages. It splits each accepted instruction into fields, extends the immediate to a configurable width and classifies the instruction type. It also adds a valid/ready handshake, a synchronous flush, load-use hazard stalling and a saturating stall-cycle counter.

## Interface
Parameters:
- PC_WIDTH, 32: width of the program-counter tag carried with each instruction.
- IMM_WIDTH, 32: width of the extended immediate; legal range 16..64.
- LOAD_OPCODE, 6'h23: opcode treated as a load for hazard detection.
- CNT_WIDTH, 16: width of the stall-cycle counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage accepts the instruction this cycle (combinational).
- instruction  in  32  raw instruction word.
- pc  in  PC_WIDTH  address of the instruction.
- flush  in  1  synchronous kill of the held entry and the current input.
- out_valid  out  1  registered decode outputs are valid.
- out_ready  in  1  downstream consumes the entry this cycle.
- opcode  out  6  bits [31:26].
- rs  out  5  bits [25:21].
- rt  out  5  bits [20:16].
- rd  out  5  bits [15:11].
- shift  out  5  bits [10:6].
- funct  out  6  bits [5:0].
- imm_ext  out  IMM_WIDTH  extended immediate.
- jump_target  out  26  bits [25:0].
- pc_out  out  PC_WIDTH  pc of the held entry.
- is_rtype  out  1  opcode == 0.
- is_jtype  out  1  opcode == 2 or 3.
- hazard  out  1  load-use stall active this cycle (combinational).
- stall_count  out  CNT_WIDTH  number of hazard cycles, saturating.

## Operation
- Single output register entry, with states EMPTY (out_valid=0) and FULL (out_valid=1).
- hazard = out_valid & (opcode==LOAD_OPCODE) & (rt!=0) & in_valid & (in_rs==rt | in_rt==rt), where in_rs and in_rt are taken from the incoming instruction.
- in_ready = flush | (~hazard & (~out_valid | out_ready)).
- Accept = in_valid & in_ready & ~flush. On accept, all field outputs, imm_ext, the type flags and pc_out load from the input, and out_valid becomes 1.
- When the entry departs (out_valid & out_ready) with no accept, out_valid becomes 0 and the fields hold their last values.
- During a hazard the held load may still depart, which leaves the stage EMPTY. The next cycle the hazard is clear, so exactly one bubble is inserted per load-use pair.
- Flush has priority over everything. Next cycle out_valid=0 and the input presented during flush is discarded; in_ready=1 during flush lets upstream drop it.
- Immediate extension rules:
  - opcode 0x0C/0x0D/0x0E: zero-extend.
  - opcode 0x0F (lui): imm<<16 when IMM_WIDTH>=32, otherwise zero-extend.
  - IMM_WIDTH==16: pass through.
  - all other opcodes: sign-extend bit 15.
- stall_count increments by 1 on each cycle where hazard=1 and saturates at all-ones.

## Timing
- Latency is 1 cycle from accept to out_valid, with fields registered. Throughput is 1 instruction per cycle with no hazard.
- Reset values: out_valid=0; every field output, imm_ext, jump_target, pc_out, type flags and stall_count = 0. hazard=0 and in_ready=1 follow combinationally.
- Reset asserted mid-transfer drops the entry immediately, with no partial state.
- Simultaneous depart and accept: the entry is replaced in the same edge and out_valid stays 1.
- Simultaneous flush and hazard: flush wins, and stall_count still increments for that cycle.
- out_valid & ~out_ready: all outputs hold stable until the entry is consumed.

## Test plan
- Reset, then stream 0x012A4020 (add $8,$9,$10) → next cycle: out_valid=1, opcode=0, rs=9, rt=10, rd=8, funct=0x20, is_rtype=1.
- addi with imm 0xFFFC at IMM_WIDTH=32 → imm_ext=0xFFFFFFFC; ori with imm 0xFFFC → 0x0000FFFC; lui with 0x1234 → 0x12340000.
- lw $8,0($9), then add $10,$8,$8 with out_ready=1 → hazard=1 for one cycle, one bubble (out_valid=0) between them, stall_count=1.
- Hold out_ready=0 for 3 cycles while FULL → in_ready=0 and outputs stable; release → entry departs and the next instruction loads.
- Assert flush while FULL with in_valid=1 → next cycle out_valid=0, input discarded, stall_count unchanged.
- CNT_WIDTH=2 with 5 consecutive hazard cycles → stall_count saturates at 3; async reset mid-stream → all outputs 0 without a clock edge.
